// File: rtl/brightness_stream_buf.sv
// brightness_stream_buf: loads one multi-channel frame, then streams it out with
// per-channel saturating add/subtract, invert or pass.
module brightness_stream_buf #(
    parameter int PIX_W    = 8,
    parameter int CHANNELS = 1,
    parameter int DEPTH    = 1024,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [CHANNELS*PIX_W-1:0] image_input,
    input  logic                      enable_process,
    input  logic [PIX_W-1:0]          bright,
    input  logic [1:0]                mode,
    output logic [CHANNELS*PIX_W-1:0] image_output,
    output logic                      out_valid,
    output logic                      finish,
    output logic                      overflow,
    output logic [CNT_W-1:0]          pix_count
);
    localparam int W  = CHANNELS * PIX_W;
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, PROC, DRAIN, DONE} state_t;
    state_t state;

    logic [W-1:0]     mem [DEPTH];
    logic [W-1:0]     rd_data, proc_pix;
    logic [AW-1:0]    rd_addr, wr_addr;
    logic             rd_req, rd_valid, full, wr_en;
    logic [CNT_W-1:0] idx;
    logic [PIX_W-1:0] bright_q, p;
    logic [1:0]       mode_q;
    logic [PIX_W:0]   sum, diff;

    assign full    = pix_count == CNT_W'(DEPTH);
    assign wr_en   = enable && (state == IDLE || state == DONE || (state == LOAD && !full));
    assign wr_addr = state == LOAD ? pix_count[AW-1:0] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= image_input;
        rd_data <= mem[rd_addr];
    end

    // Each channel is computed one bit wider so carry/borrow never leaks into a neighbour.
    always_comb begin
        proc_pix = '0;
        p        = '0;
        sum      = '0;
        diff     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            p    = rd_data[c*PIX_W +: PIX_W];
            sum  = {1'b0, p} + {1'b0, bright_q};
            diff = {1'b0, p} - {1'b0, bright_q};
            proc_pix[c*PIX_W +: PIX_W] = mode_q == 2'b00 ? p :
                                         mode_q == 2'b01 ? (sum[PIX_W] ? '1 : sum[PIX_W-1:0]) :
                                         mode_q == 2'b10 ? (diff[PIX_W] ? '0 : diff[PIX_W-1:0]) : ~p;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            image_output <= '0;
            out_valid    <= 1'b0;
            finish       <= 1'b0;
            overflow     <= 1'b0;
            pix_count    <= '0;
            rd_req       <= 1'b0;
            rd_valid     <= 1'b0;
            idx          <= '0;
        end else begin
            rd_valid     <= rd_req;
            out_valid    <= rd_valid;
            image_output <= rd_valid ? proc_pix : '0;
            rd_req       <= 1'b0;
            case (state)
                IDLE:
                    if (enable) begin
                        pix_count <= CNT_W'(1);
                        state     <= LOAD;
                    end else if (enable_process) begin
                        idx      <= '0;
                        bright_q <= bright;
                        mode_q   <= mode;
                        state    <= PROC;
                    end
                LOAD: begin
                    if (enable && full) overflow <= 1'b1;
                    if (enable && !full) pix_count <= pix_count + 1'b1;
                    if (enable_process) begin
                        idx      <= '0;
                        bright_q <= bright;
                        mode_q   <= mode;
                        state    <= PROC;
                    end
                end
                PROC:
                    if (pix_count == '0) begin
                        finish <= 1'b1;
                        state  <= DONE;
                    end else begin
                        rd_req  <= 1'b1;
                        rd_addr <= idx[AW-1:0];
                        idx     <= idx + 1'b1;
                        if (idx == pix_count - 1'b1) state <= DRAIN;
                    end
                DRAIN:
                    if (!rd_req && !rd_valid) begin
                        finish <= 1'b1;
                        state  <= DONE;
                    end
                DONE:
                    if (enable) begin
                        finish    <= 1'b0;
                        overflow  <= 1'b0;
                        pix_count <= CNT_W'(1);
                        state     <= LOAD;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_brightness_stream_buf.sv
// tb_brightness_stream_buf: directed scenarios on a 3-channel, 4-deep instance.
module tb_brightness_stream_buf;
    logic        clk = 1'b0;
    logic        rst, enable, enable_process, out_valid, finish, overflow;
    logic [23:0] image_input, image_output;
    logic [7:0]  bright;
    logic [1:0]  mode;
    logic [2:0]  pix_count;
    logic [23:0] outs [16];
    int          checks = 0, failures = 0, n, first, done_at;

    brightness_stream_buf #(.PIX_W(8), .CHANNELS(3), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .image_input(image_input),
        .enable_process(enable_process), .bright(bright), .mode(mode),
        .image_output(image_output), .out_valid(out_valid), .finish(finish),
        .overflow(overflow), .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] rep(input logic [7:0] v);
        return {v, v, v};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [23:0] v);
        enable      = 1'b1;
        image_input = v;
        step;
        enable = 1'b0;
    endtask

    // Pulses enable_process and records the streamed beats until finish or a 20-cycle budget.
    task automatic run_frame(input logic [1:0] m, input logic [7:0] b);
        mode           = m;
        bright         = b;
        enable_process = 1'b1;
        step;
        enable_process = 1'b0;
        enable         = 1'b0;
        n = 0; first = -1; done_at = -1;
        for (int k = 1; k <= 20 && done_at < 0; k++) begin
            step;
            if (out_valid) begin
                if (first < 0) first = k;
                if (n < 16) outs[n] = image_output;
                n++;
            end
            if (finish) done_at = k;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b1; enable_process = 1'b1; image_input = 24'h123456;
        bright = 8'd9; mode = 2'b01;
        step; step;
        rst = 1'b0; enable = 1'b0; enable_process = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (image_output !== 24'h0) begin failures++; $display("FAIL reset_out got=%h exp=0", image_output); end
        checks++; if (finish !== 1'b0) begin failures++; $display("FAIL reset_finish got=%b exp=0", finish); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (pix_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", pix_count); end
    endtask

    task automatic test_add;
        logic [23:0] exp [4];
        exp = '{rep(70), rep(160), rep(255), rep(255)};
        load(rep(10)); load(rep(100)); load(rep(200)); load(rep(250));
        checks++; if (pix_count !== 3'd4) begin failures++; $display("FAIL add_count got=%0d exp=4", pix_count); end
        run_frame(2'b01, 8'd60);
        checks++; if (n !== 4) begin failures++; $display("FAIL add_beats got=%0d exp=4", n); end
        checks++; if (first !== 3) begin failures++; $display("FAIL add_latency got=%0d exp=3", first); end
        checks++; if (done_at !== 7) begin failures++; $display("FAIL add_finish_at got=%0d exp=7", done_at); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (outs[i] !== exp[i]) begin failures++; $display("FAIL add_beat%0d got=%h exp=%h", i, outs[i], exp[i]); end
        end
        step; step; step;
        checks++; if (finish !== 1'b1) begin failures++; $display("FAIL add_finish_held got=%b exp=1", finish); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_valid_after got=%b exp=0", out_valid); end
    endtask

    task automatic test_sub_inv;
        logic [23:0] exp_s [3], exp_i [3];
        exp_s = '{rep(0), rep(0), rep(195)};
        exp_i = '{rep(250), rep(195), rep(0)};
        load(rep(5)); load(rep(60)); load(rep(255));
        checks++; if (finish !== 1'b0) begin failures++; $display("FAIL reload_finish got=%b exp=0", finish); end
        checks++; if (pix_count !== 3'd3) begin failures++; $display("FAIL sub_count got=%0d exp=3", pix_count); end
        run_frame(2'b10, 8'd60);
        checks++; if (n !== 3) begin failures++; $display("FAIL sub_beats got=%0d exp=3", n); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (outs[i] !== exp_s[i]) begin failures++; $display("FAIL sub_beat%0d got=%h exp=%h", i, outs[i], exp_s[i]); end
        end
        load(rep(5)); load(rep(60)); load(rep(255));
        run_frame(2'b11, 8'd60);
        checks++; if (n !== 3) begin failures++; $display("FAIL inv_beats got=%0d exp=3", n); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (outs[i] !== exp_i[i]) begin failures++; $display("FAIL inv_beat%0d got=%h exp=%h", i, outs[i], exp_i[i]); end
        end
    endtask

    task automatic test_multichan;
        load(24'hFA0A00);
        run_frame(2'b01, 8'd10);
        checks++; if (n !== 1) begin failures++; $display("FAIL mc_beats got=%0d exp=1", n); end
        checks++; if (outs[0] !== 24'hFF140A) begin failures++; $display("FAIL mc_pixel got=%h exp=ff140a", outs[0]); end
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= 5; i++) load(rep(8'(i)));
        enable      = 1'b1;
        image_input = rep(6);
        run_frame(2'b00, 8'd0);
        checks++; if (pix_count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", pix_count); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        checks++; if (n !== 4) begin failures++; $display("FAIL ovf_beats got=%0d exp=4", n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (outs[i] !== rep(8'(i + 1))) begin failures++; $display("FAIL ovf_beat%0d got=%h exp=%h", i, outs[i], rep(8'(i + 1))); end
        end
    endtask

    task automatic test_latch_reset;
        logic [23:0] exp [3];
        exp = '{rep(70), rep(160), rep(255)};
        load(rep(10)); load(rep(100)); load(rep(200)); load(rep(250));
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        mode = 2'b01; bright = 8'd60; enable_process = 1'b1;
        step;
        enable_process = 1'b0; mode = 2'b11; bright = 8'd200;
        enable = 1'b1; image_input = rep(99);
        n = 0;
        for (int k = 1; k <= 5; k++) begin
            step;
            if (k == 2) enable = 1'b0;
            if (out_valid) begin
                if (n < 16) outs[n] = image_output;
                n++;
            end
        end
        checks++; if (pix_count !== 3'd4) begin failures++; $display("FAIL proc_enable_ignored got=%0d exp=4", pix_count); end
        checks++; if (n !== 3) begin failures++; $display("FAIL latch_beats got=%0d exp=3", n); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (outs[i] !== exp[i]) begin failures++; $display("FAIL latch_beat%0d got=%h exp=%h", i, outs[i], exp[i]); end
        end
        rst = 1'b1;
        step;
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_rst_valid got=%b exp=0", out_valid); end
        checks++; if (image_output !== 24'h0) begin failures++; $display("FAIL drain_rst_out got=%h exp=0", image_output); end
        checks++; if (finish !== 1'b0) begin failures++; $display("FAIL drain_rst_finish got=%b exp=0", finish); end
        checks++; if (pix_count !== 3'd0) begin failures++; $display("FAIL drain_rst_count got=%0d exp=0", pix_count); end
    endtask

    task automatic test_empty;
        run_frame(2'b01, 8'd60);
        checks++; if (n !== 0) begin failures++; $display("FAIL empty_beats got=%0d exp=0", n); end
        checks++; if (done_at < 1 || done_at > 2) begin failures++; $display("FAIL empty_finish_at got=%0d exp=1..2", done_at); end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; enable_process = 1'b0;
        image_input = '0; bright = '0; mode = '0;
        test_reset;
        test_add;
        test_sub_inv;
        test_multichan;
        test_overflow;
        test_latch_reset;
        test_empty;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/brightness_stream_buf.md
Name: brightness_stream_buf

Overview:
Parametrised successor to the single-channel brightness filter. It runs in two phases:
- Load phase: captures one frame of multi-channel pixels into an internal buffer.
- Process phase: streams the frame back out with a per-channel saturating brightness or invert operation, flagging each output beat valid and signalling frame completion.

It sits between the pixel file/stream source and downstream filters in the image pipeline.

Parameters:
PIX_W, 8, bits per channel sample
CHANNELS, 1, channels per pixel, packed with channel 0 in LSBs
DEPTH, 1024, maximum pixels per frame held in the buffer
CNT_W, $clog2(DEPTH+1), width of pixel counter/address

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
enable  input  1  load strobe; image_input is written on every cycle this is high
image_input  input  CHANNELS*PIX_W  packed pixel to store
enable_process  input  1  request to start streaming the stored frame
bright  input  PIX_W  brightness offset, unsigned
mode  input  2  00 pass, 01 saturating add, 10 saturating subtract, 11 invert
image_output  output  CHANNELS*PIX_W  processed pixel, registered
out_valid  output  1  image_output holds a valid pixel this cycle
finish  output  1  frame streamed out; level, held until reset or a new load
overflow  output  1  sticky: a load beat was dropped because the buffer was full
pix_count  output  CNT_W  number of pixels currently stored

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, named rst. It overrides everything, including mid-load and mid-stream.
- Reset values: image_output=0, out_valid=0, finish=0, overflow=0, pix_count=0, state=IDLE. Buffer contents are don't-care.
- FSM states: IDLE, LOAD, PROC, DRAIN, DONE.
- IDLE:
  - enable=1 → write pixel at address 0, pix_count=1, go to LOAD.
  - enable_process=1 with enable=0 → go to PROC with pix_count=0.
- LOAD:
  - enable=1 → write at address pix_count and increment.
  - If pix_count==DEPTH, drop the write, set overflow, leave pix_count unchanged.
  - enable_process=1 → go to PROC. If enable is also 1 that cycle, that beat is written first (subject to the full rule).
- PROC entry: latch bright and mode into internal registers. Changes to bright or mode during PROC/DRAIN have no effect on the current frame.
- PROC:
  - Reads addresses 0..pix_count-1, one per cycle, in order.
  - Buffer read has 1-cycle latency; the output register adds 1 cycle. The pixel at address k appears on image_output with out_valid=1 exactly 2 cycles after its read is issued.
  - The first out_valid occurs on the 3rd rising edge after the edge that enters PROC.
  - After issuing the last read, go to DRAIN.
  - pix_count==0 → go straight to DONE with no out_valid.
- DRAIN: wait until the last valid beat has been emitted, then go to DONE.
- DONE:
  - finish=1 from the first cycle in DONE, held.
  - enable=1 → clear finish, pix_count and overflow; write the pixel at address 0 (pix_count=1); go to LOAD.
  - enable_process is ignored in DONE.
- out_valid is contiguous for exactly pix_count cycles. When out_valid=0, image_output=0.
- Arithmetic is per channel, independent, computed at PIX_W+1 bits:
  - 00 pass: p.
  - 01 add: min(p+bright, 2^PIX_W-1).
  - 10 subtract: max(p-bright, 0).
  - 11 invert: (2^PIX_W-1)-p; bright ignored.
  - No carry or borrow crosses channel boundaries.
- enable during PROC/DRAIN is ignored: no writes, no state change.
- overflow is sticky until rst or a new load from DONE.

Test Plan:
- Basic add, CHANNELS=1: load 4 pixels 10,100,200,250 (enable high 4 cycles), pulse enable_process with bright=60, mode=01 → out_valid for 4 consecutive cycles with outputs 70,160,255,255; first valid on the 3rd edge after PROC entry; finish rises after the last beat and stays high.
- Subtract and invert: frame 5,60,255 with bright=60. mode=10 → 0,0,195. Reload from DONE with the same data, mode=11 → 250,195,0.
- Multi-channel, CHANNELS=3: pixel {ch2=250,ch1=10,ch0=0}, bright=10, mode=01 → {255,20,10}; ch2 saturation does not disturb ch1 or ch0.
- Overflow and simultaneous events, DEPTH=4: drive 6 load beats, the 6th with enable_process also high → pix_count=4, overflow=1, exactly 4 outputs matching the first 4 inputs.
- Mid-frame latching and reset: change mode from 01 to 11 and bright during PROC → remaining outputs still use add/60. Assert rst during DRAIN → next cycle out_valid=0, image_output=0, finish=0, pix_count=0.
- Empty frame: enable_process from IDLE with no loads → no out_valid ever, finish=1 within 2 cycles.
